// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, sign_mask
// constants understood by the data memory, and the instruction-memory offset.
package dmem_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3,
        S_DONE      = 3'd4
    } dmem_state_e;

    localparam logic [3:0] MASK_B      = 4'b0001;
    localparam logic [3:0] MASK_H      = 4'b0011;
    localparam logic [3:0] MASK_W      = 4'b0111;
    localparam logic [3:0] MASK_SIGNED = 4'b1000;

    localparam logic [31:0] IMEM_OFFSET = 32'h0000_1000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant with a last-granted pointer; FAIR=0 degrades to fixed
// priority where port 0 always wins a tie.
module rr_arbiter2 #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       adv_port,
    output logic       gnt_valid,
    output logic       gnt_port
);

    logic last_port;

    // Pointer starts at port 1 so port 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_port <= 1'b1;
        end else if (advance) begin
            last_port <= adv_port;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_port  = 1'b0;
        if (req == 2'b11) begin
            gnt_port = (FAIR != 0) ? ~last_port : 1'b0;
        end else begin
            gnt_port = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU port (0) and the
// DMA/debug port (1), sequencing one command per grant through the stall window.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int FAIR    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p0_mask,
    input  logic [3:0]  p1_mask,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: a port raises req with we/addr/wdata/mask valid and holds them
    // until its one-cycle ack; no new grant is made during an ack cycle, so a
    // requester that drops req on seeing ack is never granted twice.

    dmem_state_e   state, state_n;
    logic          we_q;
    logic          port_q;
    logic [CW-1:0] to_cnt;
    logic [1:0]    arb_req;
    logic          gnt_valid, gnt_port;
    logic          grant, finish, timeout;

    assign arb_req   = (p0_ack || p1_ack) ? 2'b00 : {p1_req, p0_req};
    assign dbg_state = state;

    rr_arbiter2 #(.FAIR(FAIR)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (arb_req),
        .advance   (finish | timeout),
        .adv_port  (port_q),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The memory re-latches its command whenever idle, so read/write may only
    // be asserted in ISSUE.
    always_comb begin
        state_n   = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        grant     = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_valid) begin
                    grant   = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_read  = ~we_q;
                mem_write = we_q;
                state_n   = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (mem_stall) begin
                    state_n = S_WAIT_FALL;
                end else if (to_cnt == CW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WAIT_FALL: begin
                if (!mem_stall) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q          <= 1'b0;
            port_q        <= 1'b0;
            to_cnt        <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_sign_mask <= '0;
            p0_ack        <= 1'b0;
            p1_ack        <= 1'b0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
            err           <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (grant) begin
                port_q        <= gnt_port;
                we_q          <= gnt_port ? p1_we    : p0_we;
                mem_addr      <= gnt_port ? p1_addr  : p0_addr;
                mem_wdata     <= gnt_port ? p1_wdata : p0_wdata;
                mem_sign_mask <= gnt_port ? p1_mask  : p0_mask;
            end
            if (state == S_ISSUE) begin
                to_cnt <= '0;
            end else if (state == S_WAIT_RISE) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (timeout) begin
                err <= 1'b1;
            end
            if (finish || timeout) begin
                if (port_q) begin
                    p1_ack <= 1'b1;
                end else begin
                    p0_ack <= 1'b1;
                end
            end
            // A timed-out transaction returns zero; completed writes keep rdata.
            if (timeout || (finish && !we_q)) begin
                if (port_q) begin
                    p1_rdata <= timeout ? 32'h0 : mem_rdata;
                end else begin
                    p0_rdata <= timeout ? 32'h0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory (1024-word block, word-addressed, multi-cycle, handshake via memread/memwrite pulse and clk_stall).
- Shares the memory between the CPU load/store port (port 0) and a DMA/debug port (port 1), each with a req/ack handshake.
- Issues exactly one one-cycle memory command per granted request, waits for the stall window to close, then returns read data and ack.
- Sits between the CPU datapath, the DMA/debug master and the data memory.

Parameters:
- TIMEOUT, 8: cycles to wait for mem_stall to rise after a command before flagging an error.
- FAIR, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- p0_req, p1_req  in  1 each  request; held high until the matching ack.
- p0_we, p1_we  in  1 each  1 = write, 0 = read; sampled at grant.
- p0_addr, p1_addr  in  32 each  byte address; sampled at grant.
- p0_wdata, p1_wdata  in  32 each  store data; sampled at grant.
- p0_mask, p1_mask  in  4 each  sign_mask encoding (bit3 signed, bit2 word, bit1 half); sampled at grant.
- p0_ack, p1_ack  out  1 each  one-cycle pulse, transaction complete.
- p0_rdata, p1_rdata  out  32 each  read result, valid in the ack cycle, held until the next ack on that port.
- mem_addr, mem_wdata  out  32 each  to memory addr/write_data.
- mem_sign_mask  out  4  to memory sign_mask.
- mem_read, mem_write  out  1 each  to memory memread/memwrite.
- mem_rdata  in  32  from memory read_data.
- mem_stall  in  1  from memory clk_stall.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async): state IDLE; all outputs 0; last-grant pointer = port 1, so port 0 wins the first tie.
- States: IDLE -> ISSUE -> WAIT_RISE -> WAIT_FALL -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick the winner: round-robin gives the port not granted last; with FAIR=0, port 0 always wins.
  - Latch the winner's we/addr/wdata/mask into the mem_* registers; go to ISSUE.
- ISSUE (1 cycle):
  - mem_read = ~we, mem_write = we, both combinationally decoded from the latched we.
  - mem_addr, mem_wdata and mem_sign_mask stay stable from ISSUE through DONE.
  - Go to WAIT_RISE.
- Rules for mem_read/mem_write:
  - High only in ISSUE; never both high.
  - Must be 0 in every other state, because the memory re-latches its command whenever it is idle.
- WAIT_RISE:
  - mem_stall = 1 -> WAIT_FALL.
  - After TIMEOUT cycles without a rise: set err, ack the port with rdata = 0, return to IDLE.
- WAIT_FALL:
  - mem_stall = 0 -> DONE.
  - Expected timing, command issued in cycle t: read has stall high in t+1..t+2; write has stall high in t+1 only.
- DONE (1 cycle):
  - Capture mem_rdata into the winner's rdata; writes leave rdata unchanged.
  - Pulse the winner's ack; update the last-grant pointer; go to IDLE.
- Latency from req high in IDLE to ack: read 6 cycles, write 5 cycles.
- Next grant earliest the cycle after DONE; no back-to-back overlap.
- A req dropped before its ack is a protocol violation. The transaction still completes and is acked.
- Simultaneous requests: exactly one is granted; the loser stays pending and is granted next (both modes, provided the winner deasserts).
- Reset mid-transaction: immediate return to IDLE, no ack. A write already latched by the memory may still complete; the bench must not rely on it either way.
- Byte, half and word selection and sign extension are done by the memory; the arbiter passes mask and addr through unchanged.

Decomposition:
- Shared package dmem_pkg:
  - State encodings.
  - Mask constants: MASK_B = 4'b0001, MASK_H = 4'b0011, MASK_W = 4'b0111, MASK_SIGNED = 4'b1000.
  - Instruction-memory offset constant.
- One natural sub-module: rr_arbiter2 (2-input round-robin grant with pointer and FAIR mode).

Test Plan:
- Single read: write 0xDEADBEEF to 0x1000 beforehand; p0 reads addr 0x1000, mask 0x7 -> mem_read high exactly 1 cycle; p0_ack 6 cycles after req; p0_rdata = 0xDEADBEEF.
- Signed byte read: word 0x000080FF at 0x1004; p1 reads addr 0x1005, mask 0x9 -> p1_rdata = 0xFFFFFF80; mask 0x1 -> 0x00000080.
- Contention, FAIR=1: both req the same cycle after reset -> p0 acked first, then p1. Repeated continuous requests alternate p1, p0, p1.
- Contention, FAIR=0: p0 held continuously -> p1 never acked while p0 is held; p1 acked once p0 drops.
- Timeout: tie mem_stall to 0; p0 issues a write -> err = 1 and p0_ack after 1 + TIMEOUT wait cycles; err stays 1 until reset.
- Reset asserted in WAIT_FALL -> all outputs 0 asynchronously, no ack; a fresh p1 read afterwards completes correctly.
